// File: rtl/rr_arb8_enc.sv
// rr_arb8_enc: eight-way round-robin arbiter with a registered one-hot grant
// and its 8-to-3 binary encoding. A contended owner is limited to MAX_HOLD
// consecutive cycles. On release the grant passes to the next requester at
// the same edge, so there is no idle cycle between owners.
module rr_arb8_enc #(
    parameter int unsigned MAX_HOLD = 4   // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_vld
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_owner;
    logic [3:0] r_hold;
    logic [7:0] r_gnt;
    logic [2:0] r_gnt_id;
    logic       r_vld;

    logic       w_any;
    logic       w_others;
    logic       w_release;
    logic [2:0] w_base;
    logic [2:0] w_win;
    logic [7:0] w_win_oh;

    // First set bit of r, scanning base, base+1, ... with 3-bit wrap.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] base);
        logic [2:0] idx;
        logic       found;
        rr_pick = base;
        found   = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            idx = base + 3'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // 8-to-3 encoder, bit i maps to i; all-zero input encodes as 0.
    function automatic logic [2:0] enc8(input logic [7:0] oh);
        enc8 = 3'd0;
        for (int unsigned k = 0; k < 8; k++) begin
            if (oh[k]) begin
                enc8 = enc8 | 3'(k);
            end
        end
    endfunction

    // Release decision and winner selection. On release the scan starts just
    // past the old owner, so the old owner gets the lowest priority.
    always_comb begin
        w_any     = |req;
        w_others  = |(req & ~r_gnt);
        w_release = (r_state == ST_GRANT) &&
                    (done || !req[r_owner] || ((r_hold == HOLD_LAST) && w_others));
        w_base    = w_release ? (r_owner + 3'd1) : r_ptr;
        w_win     = rr_pick(req, w_base);
        w_win_oh  = 8'b0000_0001 << w_win;
    end

    // Arbitration state machine with registered grant outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_hold   <= '0;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_vld    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state  <= ST_GRANT;
                        r_owner  <= w_win;
                        r_hold   <= '0;
                        r_gnt    <= w_win_oh;
                        r_gnt_id <= w_win;
                        r_vld    <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_ptr <= r_owner + 3'd1;
                        if (w_any) begin
                            r_owner  <= w_win;
                            r_hold   <= '0;
                            r_gnt    <= w_win_oh;
                            r_gnt_id <= w_win;
                            r_vld    <= 1'b1;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_hold   <= '0;
                            r_gnt    <= '0;
                            r_gnt_id <= '0;
                            r_vld    <= 1'b0;
                        end
                    end else if (r_hold != HOLD_LAST) begin
                        r_hold <= r_hold + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign gnt_vld = r_vld;

    // Output invariants: at most one grant, consistent encoding and valid.
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_gnt_enc:     assert property (@(posedge clk) disable iff (rst) gnt_id == enc8(gnt));
    a_gnt_vld:     assert property (@(posedge clk) disable iff (rst) gnt_vld == (|gnt));

endmodule

// File: tb/tb_rr_arb8_enc.sv
// Self-checking bench for rr_arb8_enc: a behavioural reference model pushes
// expected outputs into a queue as each input vector is driven, and they are
// popped and compared one clock later. Directed scenarios add fixed expectations.
module tb_rr_arb8_enc;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt,     gnt1;
    logic [2:0] gnt_id,  gnt_id1;
    logic       gnt_vld, gnt_vld1;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [11:0] exp_q[$];

    // Reference model state
    bit m_vld;
    int m_ptr, m_owner, m_hold;

    always #5 clk = ~clk;

    rr_arb8_enc #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_vld(gnt_vld)
    );

    rr_arb8_enc #(.MAX_HOLD(1)) dut_h1 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt1), .gnt_id(gnt_id1), .gnt_vld(gnt_vld1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int base);
        for (int k = 0; k < 8; k++) begin
            if (r[(base + k) % 8]) return (base + k) % 8;
        end
        return 0;
    endfunction

    function automatic logic [2:0] encode(input logic [7:0] v);
        logic [2:0] e = 3'd0;
        for (int k = 0; k < 8; k++) if (v[k]) e = 3'(k);
        return e;
    endfunction

    task automatic model_reset();
        m_vld = 1'b0; m_ptr = 0; m_owner = 0; m_hold = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [7:0] r, input logic d);
        logic [7:0] others;
        bit         rel;
        if (!m_vld) begin
            if (r != 8'h00) begin
                m_owner = pick(r, m_ptr);
                m_vld   = 1'b1;
                m_hold  = 0;
            end
        end else begin
            others          = r;
            others[m_owner] = 1'b0;
            rel = d || !r[m_owner] || (m_hold == MH - 1 && others != 8'h00);
            if (rel) begin
                m_ptr = (m_owner + 1) % 8;
                if (r != 8'h00) begin
                    m_owner = pick(r, m_ptr);
                    m_hold  = 0;
                end else begin
                    m_vld = 1'b0;
                end
            end else if (m_hold < MH - 1) begin
                m_hold++;
            end
        end
        if (m_vld) exp_q.push_back({1'b1, 3'(m_owner), 8'(1 << m_owner)});
        else       exp_q.push_back(12'h000);
    endtask

    // Apply one vector at posedge+1, then compare just after the next edge.
    task automatic drive(input logic [7:0] r, input logic d);
        logic [11:0] e;
        req  = r;
        done = d;
        model_step(r, d);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'(1), 32'(0));
        end else begin
            e = exp_q.pop_front();
            chk("gnt",     32'(gnt),     32'(e[7:0]));
            chk("gnt_id",  32'(gnt_id),  32'(e[10:8]));
            chk("gnt_vld", 32'(gnt_vld), 32'(e[11]));
            chk("enc1",    32'(gnt_id1), 32'(encode(gnt1)));
            chk("vld1",    32'(gnt_vld1), 32'(|gnt1));
            chk("onehot1", 32'($countones(gnt1) <= 1), 32'(1));
        end
    endtask

    // Assert reset between edges, check asynchronous clear, hold across an edge.
    task automatic do_reset(input logic [7:0] r);
        rst  = 1'b1;
        req  = r;
        done = 1'b0;
        #2;
        chk("rst_async_gnt",  32'(gnt),     32'(0));
        chk("rst_async_vld",  32'(gnt_vld), 32'(0));
        chk("rst_async_id",   32'(gnt_id),  32'(0));
        chk("rst_async_gnt1", 32'(gnt1),    32'(0));
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_hold_gnt", 32'(gnt),     32'(0));
        chk("rst_hold_vld", 32'(gnt_vld), 32'(0));
        chk("rst_hold_id",  32'(gnt_id),  32'(0));
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rr;
        logic       dd;

        // 1: reset with all requests, then asynchronous reset mid-grant
        do_reset(8'hFF);
        drive(8'hFF, 1'b0);
        chk("t1_grant0", 32'(gnt), 32'h01);
        #1;
        do_reset(8'hFF);

        // 2: single requester held, then released
        do_reset(8'h08);
        drive(8'h08, 1'b0);
        chk("t2_id", 32'(gnt_id), 32'(3));
        repeat (20) drive(8'h08, 1'b0);
        chk("t2_held", 32'(gnt), 32'h08);
        drive(8'h00, 1'b0);
        chk("t2_drop", 32'(gnt), 32'h00);

        // 3: full rotation with done every cycle
        do_reset(8'hFF);
        for (int k = 0; k < 10; k++) begin
            drive(8'hFF, 1'b1);
            chk("t3_rot_id", 32'(gnt_id), 32'(k % 8));
        end

        // 4: hold limit (MAX_HOLD=4) and per-cycle rotation (MAX_HOLD=1)
        do_reset(8'h24);
        for (int c = 0; c < 16; c++) begin
            drive(8'h24, 1'b0);
            chk("t4_hold_id", 32'(gnt_id),  32'(((c / 4) % 2) ? 5 : 2));
            chk("t4_h1_id",   32'(gnt_id1), 32'((c % 2) ? 5 : 2));
        end

        // 5: wrap-around from owner 7
        do_reset(8'h00);
        drive(8'h80, 1'b0);
        chk("t5_own7", 32'(gnt_id), 32'(7));
        drive(8'hC1, 1'b1);
        chk("t5_wrap0", 32'(gnt_id), 32'(0));
        drive(8'hC1, 1'b1);
        chk("t5_next6", 32'(gnt_id), 32'(6));

        // 6: done and req drop together, new request in the same cycle
        do_reset(8'h00);
        drive(8'h08, 1'b0);
        chk("t6_own3", 32'(gnt_id), 32'(3));
        drive(8'h10, 1'b1);
        chk("t6_gnt4", 32'(gnt), 32'h10);
        chk("t6_vld",  32'(gnt_vld), 32'(1));
        drive(8'h31, 1'b1);
        chk("t6_ptr5", 32'(gnt_id), 32'(5));

        // Random traffic against the reference model
        do_reset(8'h00);
        repeat (300) begin
            rr = 8'($urandom) & 8'($urandom);
            dd = ($urandom_range(0, 3) == 0);
            drive(rr, dd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_arb8_enc.md
# rr_arb8_enc

Round-robin arbiter that shares one downstream resource among eight requesters. It issues a registered one-hot grant plus its 3-bit binary encoding, so the grant vector matches the 8-to-3 encoder convention used in this design. The block sits between the requesting units and the shared datapath. Its three jobs are:
- rotate priority between requesters;
- bound how long a contended owner keeps the grant;
- hand the grant directly to the next requester with no idle bubble.

## Interface
Parameters:
- MAX_HOLD, default 4: maximum consecutive grant cycles for an owner while any other requester is pending. Legal range is 1..15.

Ports:
- clk, input, 1: the single clock. All state updates on the rising edge.
- rst, input, 1: reset. Asynchronous and active-high.
- req, input, 8: request lines. Bit i set means requester i wants the resource. Level-sensitive.
- done, input, 1: the current owner releases the resource. Sampled only while gnt_vld=1.
- gnt, output, 8: registered one-hot grant. All-zero when no owner.
- gnt_id, output, 3: binary index of the set bit of gnt, using 8-to-3 encoder mapping (bit i → i). Holds 0 when gnt=0.
- gnt_vld, output, 1: equals |gnt.

## Operation
Internal state:
- state: IDLE or GRANT.
- ptr[2:0]: highest-priority index.
- owner[2:0]: index of the current grant holder.
- hold_cnt[3:0]: grant cycles used by the current owner.

Selection (combinational):
- Scan req starting at ptr, in order ptr, ptr+1, …, ptr+7 (mod 8).
- The first set bit wins. Index arithmetic is 3-bit with natural wrap, so 7+1 gives 0.

IDLE:
- If req≠0: register the winner into gnt/gnt_id, set gnt_vld=1, hold_cnt=0, go to GRANT.
- Else stay in IDLE with all outputs 0.

GRANT: the owner is released at the next edge if any of these holds:
- (a) done=1;
- (b) req[owner]=0;
- (c) hold_cnt==MAX_HOLD-1 and at least one other req bit is set.

Release handling:
- ptr ← owner+1 (mod 8). The scan for the new grant uses this updated ptr, so the old owner has lowest priority.
- If req has any bit set, including the old owner's bit, the winner is granted at the same edge (back-to-back handoff, hold_cnt ← 0).
- Otherwise outputs go to 0 and the state returns to IDLE.

No release:
- Grant is held and hold_cnt increments, saturating at MAX_HOLD-1.
- An uncontended owner keeps the grant indefinitely.

Output invariants, checked every cycle:
- gnt has zero or one bit set.
- gnt_id equals the encoding of gnt.
- gnt_vld equals |gnt.

done while gnt_vld=0 is ignored. A done that coincides with the owner's req falling counts as a single release.

## Timing
Reset:
- While rst=1: gnt=8'h00, gnt_id=3'd0, gnt_vld=0, ptr=0, hold_cnt=0, state=IDLE.
- Outputs clear asynchronously, without waiting for a clock edge.
- After rst deasserts, the first rising edge with req≠0 produces a grant.

Latency:
- req rising to gnt: 1 cycle (visible after the next rising edge).
- Release condition to next grant: 1 cycle, with no idle cycle between owners.

Hold bound:
- Under contention, an owner holds for at most MAX_HOLD consecutive cycles.
- With MAX_HOLD=1, grants rotate every cycle while two or more requesters are active.

Other boundary cases:
- A requester that drops req before being granted is simply skipped.
- A request that appears in the same cycle as a release competes in that cycle's scan.
- rst asserted mid-grant clears the grant immediately. After reset release, priority restarts from index 0.

## Test plan
1. Reset: hold rst with req=8'hFF. Required: gnt=0, gnt_vld=0, gnt_id=0. Assert rst asynchronously mid-grant; outputs clear before the next edge.
2. Single requester: req=8'h08 from reset. Required: one edge later gnt=8'h08, gnt_id=3, gnt_vld=1, held for 20 cycles. Drop req; next edge gnt=0.
3. Full rotation: req=8'hFF, done=1 every cycle. Required: gnt_id sequence 0,1,2,3,4,5,6,7,0,1, one grant per cycle, no gaps.
4. Hold limit: MAX_HOLD=4, req=8'h24, done=0. Required: gnt_id=2 for 4 cycles, then 5 for 4 cycles, then 2 again, repeating.
5. Wrap-around: owner 7, req=8'hC1, then done=1. Required: next grant is index 0, not 6. The following done grants 6.
6. Simultaneous events: owner 3 asserts done and drops req[3] in the same cycle, while req[4] rises in that cycle. Required: next edge gnt=8'h10, gnt_id=4, no idle cycle, one release counted (ptr becomes 4, then 5 after owner 4's release).
